// File: rtl/store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer: defaults, size
// encodings, entry layout and the strobe-to-size decoder.
package store_buffer_pkg;

  localparam int SB_DEPTH    = 4;
  localparam int ADDR_W      = 32;
  localparam int WORD_ADDR_W = ADDR_W - 2;
  localparam int STRB_W      = 4;
  localparam int DATA_W      = 32;

  typedef enum logic [1:0] {
    SZ_ILL  = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } sizeE;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] wordAddr;
    logic [STRB_W-1:0]      wstrb;
    logic [DATA_W-1:0]      wdata;
  } sbEntryT;

  // Access size follows the number of enabled lanes; 0 or 3 lanes is illegal.
  function automatic sizeE decodeSize(input logic [STRB_W-1:0] strb);
    logic [2:0] ones;
    ones = {2'b0, strb[0]} + {2'b0, strb[1]} + {2'b0, strb[2]} + {2'b0, strb[3]};
    case (ones)
      3'd1:    return SZ_BYTE;
      3'd2:    return SZ_HALF;
      3'd4:    return SZ_WORD;
      default: return SZ_ILL;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Replicates unaligned store data onto all byte lanes according to the
// access size implied by the strobe; flags illegal strobe patterns.
module store_lane_align
  import store_buffer_pkg::*;
(
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] alignedData,
  output logic              legal
);

  sizeE size;

  assign size = decodeSize(wstrb);

  always_comb begin
    alignedData = data;
    legal       = 1'b1;
    case (size)
      SZ_BYTE: alignedData = {4{data[7:0]}};
      SZ_HALF: alignedData = {2{data[15:0]}};
      SZ_WORD: alignedData = data;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the store stage and the data-memory bus, with
// full/empty status and a word-address hazard check for younger loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iRAM_CE,
  input  logic        iRAM_WR,
  input  logic [3:0]  iRAM_WSTRB,
  input  logic [31:0] iRAM_ADDR,
  input  logic [31:0] iRAM_DATA,
  output logic        oFULL,
  output logic        oEMPTY,
  input  logic        iLD_EN,
  input  logic [31:0] iLD_ADDR,
  output logic        oLD_HIT,
  output logic        oBUS_VALID,
  input  logic        iBUS_READY,
  output logic [31:0] oBUS_ADDR,
  output logic [3:0]  oBUS_WSTRB,
  output logic [31:0] oBUS_WDATA
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW:0]             count;
  logic [AW-1:0]           wrPtr, rdPtr;
  logic [DEPTH-1:0]        occ, occNext, hitVec;
  logic [WORD_ADDR_W-1:0]  addrMem [DEPTH];
  logic [STRB_W-1:0]       strbMem [DEPTH];
  logic [DATA_W-1:0]       dataMem [DEPTH];
  logic [DATA_W-1:0]       alignedData;
  logic                    legal, push, pop, full, empty;
  sbEntryT                 head;
  logic                    unusedBits;

  store_lane_align uAlign (
    .wstrb      (iRAM_WSTRB),
    .data       (iRAM_DATA),
    .alignedData(alignedData),
    .legal      (legal)
  );

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign push  = iRAM_CE & iRAM_WR & legal & ~full;
  assign pop   = ~empty & iBUS_READY;

  // Push and pop never target the same slot: that needs count 0 or DEPTH.
  always_comb begin
    occNext = occ;
    if (pop)  occNext[rdPtr] = 1'b0;
    if (push) occNext[wrPtr] = 1'b1;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      occ <= occNext;
    end
  end

  // Entry payload is don't-care until occupied, so it carries no reset.
  always_ff @(posedge iCLK) begin
    if (push) begin
      addrMem[wrPtr] <= iRAM_ADDR[31:2];
      strbMem[wrPtr] <= iRAM_WSTRB;
      dataMem[wrPtr] <= alignedData;
    end
  end

  always_comb begin
    head = '0;
    if (!empty) begin
      head.wordAddr = addrMem[rdPtr];
      head.wstrb    = strbMem[rdPtr];
      head.wdata    = dataMem[rdPtr];
    end
  end

  assign oFULL      = full;
  assign oEMPTY     = empty;
  assign oBUS_VALID = ~empty;
  assign oBUS_ADDR  = {head.wordAddr, 2'b00};
  assign oBUS_WSTRB = head.wstrb;
  assign oBUS_WDATA = head.wdata;

  // A popping head still reports a hit; a same-cycle push is not yet occupied.
  for (genvar i = 0; i < DEPTH; i++) begin : gHit
    assign hitVec[i] = occ[i] & (addrMem[i] == iLD_ADDR[31:2]);
  end

  assign oLD_HIT = iLD_EN & (|hitVec);

  assign unusedBits = ^{iRAM_ADDR[1:0], iLD_ADDR[1:0]};

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        iCLK, iRST_N;
  logic        iRAM_CE, iRAM_WR;
  logic [3:0]  iRAM_WSTRB;
  logic [31:0] iRAM_ADDR, iRAM_DATA;
  logic        oFULL, oEMPTY;
  logic        iLD_EN;
  logic [31:0] iLD_ADDR;
  logic        oLD_HIT;
  logic        oBUS_VALID, iBUS_READY;
  logic [31:0] oBUS_ADDR;
  logic [3:0]  oBUS_WSTRB;
  logic [31:0] oBUS_WDATA;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iRAM_CE(iRAM_CE), .iRAM_WR(iRAM_WR), .iRAM_WSTRB(iRAM_WSTRB),
    .iRAM_ADDR(iRAM_ADDR), .iRAM_DATA(iRAM_DATA),
    .oFULL(oFULL), .oEMPTY(oEMPTY),
    .iLD_EN(iLD_EN), .iLD_ADDR(iLD_ADDR), .oLD_HIT(oLD_HIT),
    .oBUS_VALID(oBUS_VALID), .iBUS_READY(iBUS_READY),
    .oBUS_ADDR(oBUS_ADDR), .oBUS_WSTRB(oBUS_WSTRB), .oBUS_WDATA(oBUS_WDATA)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } expT;

  expT modelQ[$];   // reference contents of the buffer
  expT expQ[$];     // scoreboard of entries expected on the bus
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte lane i takes the data byte the access size maps onto it.
  function automatic bit refAlign(input logic [3:0] strb, input logic [31:0] data,
                                  output logic [31:0] lanes);
    int n;
    n = $countones(strb);
    lanes = '0;
    for (int i = 0; i < 4; i++) begin
      case (n)
        1: lanes[8*i +: 8] = data[7:0];
        2: lanes[8*i +: 8] = data[8*(i%2) +: 8];
        4: lanes[8*i +: 8] = data[8*i +: 8];
        default: ;
      endcase
    end
    return (n == 1) || (n == 2) || (n == 4);
  endfunction

  // Reference model: update buffer contents at each edge.
  expT         mE;
  logic [31:0] mLanes;
  bit          mLegal, mPop, mAcc;
  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      modelQ.delete();
    end else begin
      mLegal = refAlign(iRAM_WSTRB, iRAM_DATA, mLanes);
      mPop   = (modelQ.size() > 0) && iBUS_READY;
      mAcc   = iRAM_CE && iRAM_WR && mLegal && (modelQ.size() < DEPTH);
      if (mPop) void'(modelQ.pop_front());
      if (mAcc) begin
        mE.addr = {iRAM_ADDR[31:2], 2'b00};
        mE.strb = iRAM_WSTRB;
        mE.data = mLanes;
        modelQ.push_back(mE);
        expQ.push_back(mE);
      end
    end
  end

  // Monitor: compare status, hazard flag and head entry away from the edge.
  bit expHit;
  always @(negedge iCLK) begin
    if (!iRST_N) begin
      expQ.delete();
    end else begin
      chk("oEMPTY", oEMPTY, modelQ.size() == 0);
      chk("oFULL", oFULL, modelQ.size() == DEPTH);
      chk("oBUS_VALID", oBUS_VALID, modelQ.size() != 0);
      expHit = 1'b0;
      foreach (modelQ[i])
        if (modelQ[i].addr[31:2] == iLD_ADDR[31:2]) expHit = 1'b1;
      chk("oLD_HIT", oLD_HIT, iLD_EN && expHit);
      if (oBUS_VALID) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sbUnderflow: bus valid with addr 0x%08h but no entry expected", oBUS_ADDR);
        end else begin
          chk("busAddr", oBUS_ADDR, expQ[0].addr);
          chk("busStrb", oBUS_WSTRB, expQ[0].strb);
          chk("busData", oBUS_WDATA, expQ[0].data);
          if (iBUS_READY) void'(expQ.pop_front());
        end
      end else begin
        chk("idleBus", {oBUS_ADDR[31:4], oBUS_ADDR[3:0] | oBUS_WSTRB}, 32'h0);
        chk("idleData", oBUS_WDATA, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic setStore(input logic ce, input logic wr, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] data);
    iRAM_CE = ce; iRAM_WR = wr; iRAM_WSTRB = strb; iRAM_ADDR = addr; iRAM_DATA = data;
  endtask

  task automatic idleIn();
    setStore(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    idleIn();
    iBUS_READY = 1'b1;
    for (int k = 0; k < 40 && !oEMPTY; k++) tick();
    chk("drainDone", oEMPTY, 1'b1);
    iBUS_READY = 1'b0;
  endtask

  logic [3:0] strbTab [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'hF,
                               4'h0, 4'h7, 4'hE, 4'h5};

  initial begin
    iRST_N = 1'b0;
    idleIn();
    iBUS_READY = 1'b0;
    iLD_EN = 1'b1;
    iLD_ADDR = 32'h0;
    repeat (2) @(negedge iCLK);
    chk("rstEmpty", oEMPTY, 1'b1);
    chk("rstFull", oFULL, 1'b0);
    chk("rstValid", oBUS_VALID, 1'b0);
    chk("rstAddr", oBUS_ADDR, 32'h0);
    chk("rstData", oBUS_WDATA, 32'h0);
    chk("rstHit", oLD_HIT, 1'b0);
    #2 iRST_N = 1'b1;
    iLD_EN = 1'b0;
    tick();

    // Byte store replicated across lanes
    setStore(1'b1, 1'b1, 4'b1000, 32'h1003, 32'h0000_00A5);
    tick();
    idleIn();
    chk("sbValid", oBUS_VALID, 1'b1);
    chk("sbAddr", oBUS_ADDR, 32'h1000);
    chk("sbStrb", oBUS_WSTRB, 4'b1000);
    chk("sbData", oBUS_WDATA, 32'hA5A5_A5A5);
    drain();

    // Halfword store
    setStore(1'b1, 1'b1, 4'b1100, 32'h2002, 32'h0000_1234);
    tick();
    idleIn();
    chk("shAddr", oBUS_ADDR, 32'h2000);
    chk("shData", oBUS_WDATA, 32'h1234_1234);
    drain();

    // Fill with READY low; fifth push must be ignored
    for (int i = 0; i < 5; i++) begin
      setStore(1'b1, 1'b1, 4'hF, 32'h4000 + 4*i, 32'hC0DE_0000 + i);
      tick();
      if (i == 3) chk("fullAfter4", oFULL, 1'b1);
    end
    idleIn();
    chk("fullHeld", oFULL, 1'b1);
    chk("fullHead", oBUS_ADDR, 32'h4000);
    iBUS_READY = 1'b1;
    repeat (4) tick();
    chk("fullDrained", oEMPTY, 1'b1);
    iBUS_READY = 1'b0;

    // One entry resident, push+pop every cycle across a pointer wrap
    setStore(1'b1, 1'b1, 4'hF, 32'h5000, 32'h5000_0000);
    tick();
    iBUS_READY = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      setStore(1'b1, 1'b1, 4'hF, 32'h5004 + 4*i, 32'h5000_0001 + i);
      tick();
      chk("ppNotEmpty", oEMPTY, 1'b0);
      chk("ppNotFull", oFULL, 1'b0);
    end
    drain();

    // Load hazard against a pending word store
    setStore(1'b1, 1'b1, 4'hF, 32'h3004, 32'hDEAD_BEEF);
    tick();
    idleIn();
    iLD_EN = 1'b1;
    iLD_ADDR = 32'h3006;
    #1 chk("hitSameWord", oLD_HIT, 1'b1);
    iLD_ADDR = 32'h3008;
    #1 chk("hitNextWord", oLD_HIT, 1'b0);
    iLD_ADDR = 32'h3006;
    iBUS_READY = 1'b1;
    #1 chk("hitPopCycle", oLD_HIT, 1'b1);
    tick();
    chk("hitAfterPop", oLD_HIT, 1'b0);
    iBUS_READY = 1'b0;

    // Same-cycle push does not count as a hit
    iLD_ADDR = 32'h6000;
    setStore(1'b1, 1'b1, 4'hF, 32'h6000, 32'h1);
    #1 chk("hitPushCycle", oLD_HIT, 1'b0);
    tick();
    idleIn();
    chk("hitPushed", oLD_HIT, 1'b1);
    iLD_EN = 1'b0;
    drain();

    // Illegal strobes and non-write requests are dropped
    setStore(1'b1, 1'b1, 4'b0000, 32'h7000, 32'h11);
    tick();
    setStore(1'b1, 1'b1, 4'b0111, 32'h7000, 32'h22);
    tick();
    setStore(1'b1, 1'b0, 4'hF, 32'h7000, 32'h33);
    tick();
    idleIn();
    chk("illegalEmpty", oEMPTY, 1'b1);

    // Reset mid-drain drops valid without a clock edge
    setStore(1'b1, 1'b1, 4'hF, 32'h8000, 32'hAAAA_0000);
    tick();
    setStore(1'b1, 1'b1, 4'h3, 32'h8004, 32'h0000_BBBB);
    tick();
    idleIn();
    iBUS_READY = 1'b1;
    chk("preRstValid", oBUS_VALID, 1'b1);
    iRST_N = 1'b0;
    #1;
    chk("midRstValid", oBUS_VALID, 1'b0);
    chk("midRstEmpty", oEMPTY, 1'b1);
    chk("midRstAddr", oBUS_ADDR, 32'h0);
    @(negedge iCLK);
    #2 iRST_N = 1'b1;
    iBUS_READY = 1'b0;
    tick();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      setStore($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
               strbTab[$urandom_range(0, 11)],
               32'h100 + 4*$urandom_range(0, 7) + $urandom_range(0, 3), $urandom);
      iBUS_READY = $urandom_range(0, 9) < 5;
      iLD_EN = $urandom_range(0, 1);
      iLD_ADDR = 32'h100 + 4*$urandom_range(0, 9) + $urandom_range(0, 3);
      tick();
    end
    iLD_EN = 1'b0;
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
